cache_controller: RTL and testbench

- Requester-side sequencer for the memory_cache subsystem. It sits between the processor's load/store port and the cache/dmem pair, and drives writeMem, writeCache and MemToCache.
- Reads that hit in the cache complete in the request cycle. Read misses stall the processor, wait out the memory latency, fill a 16-word line, then return the data.
- Stores are write-through and no-write-allocate: memory is always written, and the cache is written only on a hit.
- Hit, miss and store statistics counters are kept for performance debug.

---
 rtl/cache_controller.sv | 131 +++++++++++++
 tb/tb_cache_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Requester-side sequencer between a processor load/store port and the memory_cache/dmem pair.
// Load hits finish in the request cycle; misses wait out memory latency and fill a line; stores write through.
module cache_controller #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic             ready,
  output logic             stall,
  output logic [31:0]      c_address,
  output logic [31:0]      c_write_data,
  output logic             c_writeMem,
  output logic             c_writeCache,
  output logic             c_MemToCache,
  input  logic             c_hit,
  input  logic [31:0]      c_read_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] store_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MISS_WAIT = 3'd1,
    FILL      = 3'd2,
    RESUME    = 3'd3,
    STORE     = 3'd4
  } state_t;

  localparam logic [7:0]       WAIT_INIT = 8'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       wait_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign read_data    = c_read_data;
  assign c_address    = address;
  assign c_write_data = write_data;
  assign wait_done    = (wait_cnt == '0);

  // Handshake: the processor holds mem_read/mem_write (with address and data)
  // until ready; a request completes in exactly the cycle ready is high.
  // stall is the inverse view of that handshake for the pipeline.
  always_comb begin
    ready        = 1'b0;
    c_writeMem   = 1'b0;
    c_writeCache = 1'b0;
    c_MemToCache = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    ready = mem_read & ~mem_write & c_hit;
        FILL:    c_MemToCache = 1'b1;
        RESUME:  ready = c_hit;
        STORE: begin
          c_writeMem = 1'b1;
          if (wait_done) begin
            c_writeCache = c_hit;
            ready        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall = (mem_read | mem_write) & ~ready;

  // Once a miss or store sequence starts it runs to completion even if the
  // processor drops its request; only reset abandons it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      store_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            store_count <= sat_inc(store_count);
            wait_cnt    <= WAIT_INIT;
            state       <= STORE;
          end else if (mem_read) begin
            if (c_hit) begin
              hit_count <= sat_inc(hit_count);
            end else begin
              miss_count <= sat_inc(miss_count);
              wait_cnt   <= WAIT_INIT;
              state      <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT: begin
          if (wait_done) state <= FILL;
          else           wait_cnt <= wait_cnt - 8'd1;
        end
        FILL: state <= RESUME;
        RESUME: begin
          if (c_hit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= MISS_WAIT;
          end
        end
        STORE: begin
          if (wait_done) state <= IDLE;
          else           wait_cnt <= wait_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A line fill and a word write must never collide in the cache.
  assert property (@(posedge clk) disable iff (reset) !(c_MemToCache && c_writeCache));
  assert property (@(posedge clk) disable iff (reset) c_MemToCache |-> (state == FILL));

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural memory_cache/dmem model plus a scoreboard
// that predicts load data, latencies, enable activity and statistics counters.
module tb_cache_controller;

  localparam int L  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read, mem_write;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready, stall;
  logic [31:0]   c_address, c_write_data;
  logic          c_writeMem, c_writeCache, c_MemToCache;
  logic          c_hit;
  logic [31:0]   c_read_data;
  logic [CW-1:0] hit_count, miss_count, store_count;

  cache_controller #(.MEM_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready), .stall(stall),
    .c_address(c_address), .c_write_data(c_write_data),
    .c_writeMem(c_writeMem), .c_writeCache(c_writeCache), .c_MemToCache(c_MemToCache),
    .c_hit(c_hit), .c_read_data(c_read_data),
    .hit_count(hit_count), .miss_count(miss_count), .store_count(store_count)
  );

  always #5 clk = ~clk;

  // ---------------- memory_cache / dmem model (12-bit address space) --------
  logic [31:0] dmem [0:1023];
  bit          dmem_wr [0:1023];
  logic [31:0] cmem [0:1023];
  bit          line_valid [0:63];
  int          fills_seen = 0;
  int          fail_fill_idx = -1;

  function automatic logic [31:0] pattern(input logic [9:0] w);
    return 32'hC0DE_0000 | {22'd0, w};
  endfunction

  function automatic logic [31:0] mem_word(input logic [9:0] w);
    return dmem_wr[w] ? dmem[w] : pattern(w);
  endfunction

  always_comb begin
    c_hit       = line_valid[c_address[11:6]];
    c_read_data = c_hit ? cmem[c_address[11:2]] : mem_word(c_address[11:2]);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) line_valid[i] <= 1'b0;
    end else begin
      if (c_writeMem) begin
        dmem[c_address[11:2]]    <= c_write_data;
        dmem_wr[c_address[11:2]] <= 1'b1;
      end
      if (c_writeCache) cmem[c_address[11:2]] <= c_write_data;
      if (c_MemToCache) begin
        fills_seen <= fills_seen + 1;
        if (fills_seen != fail_fill_idx) begin
          line_valid[c_address[11:6]] <= 1'b1;
          for (int i = 0; i < 16; i++)
            cmem[{c_address[11:6], i[3:0]}] <= mem_word({c_address[11:6], i[3:0]});
        end
      end
    end
  end

  // ---------------- reference state and scoreboard ---------------------------
  logic [31:0]   ref_mem [int];
  bit            ref_valid [int];
  logic [31:0]   exp_q [$];
  int            lat_q [$];
  logic [CW-1:0] exp_hits, exp_misses, exp_stores;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int w;
    w = int'(a[11:2]);
    return ref_mem.exists(w) ? ref_mem[w] : (32'hC0DE_0000 | 32'(w));
  endfunction

  function automatic logic [CW-1:0] sat_up(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hits"},   32'(hit_count),   32'(exp_hits));
    check({tag, "_misses"}, 32'(miss_count),  32'(exp_misses));
    check({tag, "_stores"}, 32'(store_count), 32'(exp_stores));
  endtask

  // ---------------- driver tasks ---------------------------------------------
  task automatic do_load(input logic [31:0] addr, input int fail_extra);
    bit   hit, done;
    int   cyc, stalls, mtc, mtc_at, wr_en, exp_lat;
    logic [31:0] exp_data;
    hit = ref_valid.exists(int'(addr[11:6]));
    exp_q.push_back(ref_word(addr));
    lat_q.push_back(hit ? 0 : (L + 2) * (1 + fail_extra));
    if (hit) exp_hits = sat_up(exp_hits);
    else     exp_misses = sat_up(exp_misses);
    ref_valid[int'(addr[11:6])] = 1'b1;
    @(negedge clk);
    address = addr; mem_read = 1'b1; mem_write = 1'b0;
    done = 0; stalls = 0; mtc = 0; mtc_at = -1; wr_en = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (stall) stalls++;
      if (c_MemToCache) begin mtc++; if (mtc_at < 0) mtc_at = cyc; end
      if (c_writeMem || c_writeCache) wr_en++;
      if (ready) begin done = 1; break; end
      @(negedge clk);
    end
    exp_lat  = lat_q.pop_front();
    exp_data = exp_q.pop_front();
    check("ld_done", 32'(done), 32'd1);
    check("ld_c_address", c_address, addr);
    if (done) begin
      check("ld_latency", 32'(cyc), 32'(exp_lat));
      check("ld_data", read_data, exp_data);
      check("ld_stall_cycles", 32'(stalls), 32'(exp_lat));
      check("ld_fill_pulses", 32'(mtc), hit ? 32'd0 : 32'(1 + fail_extra));
      if (!hit) check("ld_fill_cycle", 32'(mtc_at), 32'(L + 1));
      check("ld_write_enables", 32'(wr_en), 32'd0);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit with_read);
    bit hit, done;
    int cyc, wm, wc, wc_at, mtc, exp_lat;
    hit = ref_valid.exists(int'(addr[11:6]));
    lat_q.push_back(L);
    ref_mem[int'(addr[11:2])] = data;
    exp_stores = sat_up(exp_stores);
    @(negedge clk);
    address = addr; write_data = data; mem_write = 1'b1; mem_read = with_read;
    done = 0; wm = 0; wc = 0; wc_at = -1; mtc = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (c_writeMem) wm++;
      if (c_writeCache) begin wc++; wc_at = cyc; end
      if (c_MemToCache) mtc++;
      if (ready) begin done = 1; break; end
      @(negedge clk);
    end
    exp_lat = lat_q.pop_front();
    check("st_done", 32'(done), 32'd1);
    check("st_c_write_data", c_write_data, data);
    if (done) begin
      check("st_latency", 32'(cyc), 32'(exp_lat));
      check("st_writemem_cycles", 32'(wm), 32'(L));
      check("st_writecache_cycles", 32'(wc), hit ? 32'd1 : 32'd0);
      if (hit) check("st_writecache_cycle", 32'(wc_at), 32'(L));
      check("st_fill_pulses", 32'(mtc), 32'd0);
    end
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  // ---------------- main sequence ---------------------------------------------
  initial begin
    logic [31:0] addr_tbl [8];
    int rdy_cycles, mtc_seen;
    addr_tbl = '{32'h40, 32'h44, 32'h48, 32'h400, 32'h404, 32'h800, 32'h840, 32'hC00};
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    exp_hits = '0; exp_misses = '0; exp_stores = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_enables", {29'd0, c_writeMem, c_writeCache, c_MemToCache}, 32'd0);
    check_counters("rst");
    reset = 1'b0;
    @(negedge clk);

    do_load(32'h40, 0);                   // cold miss
    check_counters("cold_load");
    do_load(32'h44, 0);                   // same line, hit
    check_counters("repeat_load");
    do_store(32'h44, 32'hDEAD_BEEF, 0);   // store hit
    do_load(32'h44, 0);
    check_counters("store_hit");
    do_store(32'h400, 32'h1234_5678, 0);  // store miss, no allocate
    do_load(32'h400, 0);
    check_counters("store_miss");
    do_store(32'h80, 32'hA5A5_5A5A, 1);   // read and write together: write wins
    check_counters("rd_wr_both");

    fail_fill_idx = fills_seen;           // next line fill is dropped by the cache
    do_load(32'hC0, 1);
    check_counters("fill_retry");

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(1, 0) == 1)
        do_store(addr_tbl[$urandom_range(7, 0)], $urandom(), 0);
      else
        do_load(addr_tbl[$urandom_range(7, 0)], 0);
    end
    check_counters("random");

    // Hold a hitting load for 20 cycles to drive hit_count into saturation.
    do_load(32'h40, 0);
    @(negedge clk);
    address = 32'h40; mem_read = 1'b1; rdy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready) rdy_cycles++;
      exp_hits = sat_up(exp_hits);
      @(negedge clk);
    end
    mem_read = 1'b0;
    check("sat_ready_cycles", 32'(rdy_cycles), 32'd20);
    check("sat_hit_count", 32'(hit_count), 32'hF);
    check_counters("saturate");

    // Reset in the second MISS_WAIT cycle of a miss.
    @(negedge clk);
    address = 32'hF00; mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    exp_hits = '0; exp_misses = '0; exp_stores = '0;
    ref_valid.delete();
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_enables", {29'd0, c_writeMem, c_writeCache, c_MemToCache}, 32'd0);
    check_counters("midrst");
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mtc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (c_MemToCache || c_writeMem) mtc_seen++;
    end
    check("midrst_no_enables_after", 32'(mtc_seen), 32'd0);
    do_load(32'h40, 0);                   // behaves as a cold miss again
    check_counters("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
